word_receiver: RTL
==================

Name: word_receiver

Overview:
- UART receive side of the 32-bit word link: deserializes the 4-byte word frame produced by the link transmitter.
- Publishes each complete word on data_out with a sticky ready flag.
- Sits between the board Rx pin and the FPU operand-load logic.
- Runs on clk_50m. Samples the line on a 16x-baud clken tick from the shared baud generator.

Parameters:
- OVERSAMPLE, 16, clken ticks per bit period. Must be even, >=4.
- TIMEOUT_BITS, 4, bit periods allowed between sub-frames before a partial word is abandoned.

Ports:
- clk_50m  input  1  system clock
- rst  input  1  synchronous active-high reset
- Rx  input  1  serial line, idle high, asynchronous to clk_50m
- clken  input  1  one-cycle strobe at OVERSAMPLE x baud
- rdy_clr  input  1  consumer acknowledge; clears rdy
- data_out  output  32  last complete word; byte0 = [7:0] ... byte3 = [31:24]
- rdy  output  1  sticky; a new word is valid
- frame_err  output  1  one-cycle pulse on a framing or timeout error
- Rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (clk_50m). Reset rst is synchronous and active-high.
- Reset values: data_out=0, rdy=0, frame_err=0, Rx_busy=0, state=IDLE, byte_idx=0. The 2-flop Rx synchronizer resets to 1. Reset mid-frame discards all partial data.
- Line format, per word, LSB-first bytes:
  - start(0), byte0, stop, stop
  - start(0), byte1, stop, stop
  - start(0), byte2, stop, stop
  - start(0), byte3, stop, stop
  - guard(0), final stop(1)
  - Receiver checks only the first stop bit of each sub-frame.
- All state/counter updates occur only on cycles with clken=1. rst and rdy_clr act on every cycle.
- Tick counter: 0..OVERSAMPLE-1. Bit counter: 0..7.
- IDLE: requires one tick with synced Rx=1 to arm. This blocks a stuck-low line from re-triggering. Armed and synced Rx=0 -> START, tick=0.
- START: at tick OVERSAMPLE/2-1:
  - Rx still 0 -> DATA, tick=0, bit=0.
  - Rx=1 -> false start, back to the state that entered START. No error.
- DATA: at tick OVERSAMPLE-1, shift synced Rx into shreg[7] (right shift), tick=0. After bit 7 -> STOP.
- STOP: at tick OVERSAMPLE-1, sample:
  - 1 and byte_idx<3: store byte into word[8*byte_idx +: 8], byte_idx++, -> GAP.
  - 1 and byte_idx=3: data_out <= {shreg, word[23:0]}, rdy<=1, byte_idx=0, -> GUARD.
  - 0: frame_err pulse, byte_idx=0, partial word discarded, -> IDLE (disarmed).
- GAP: wait for synced Rx=0, then -> START. If TIMEOUT_BITS*OVERSAMPLE ticks elapse first: frame_err pulse, discard, -> IDLE.
- GUARD: wait for Rx=0, then consume OVERSAMPLE+OVERSAMPLE/2 ticks, then -> IDLE. If the timeout elapses with no low, -> IDLE silently. Never produces a byte or an error.
- rdy:
  - Set on publish; cleared by rdy_clr.
  - Publish and rdy_clr on the same cycle -> rdy=1 (set wins).
  - Publish while rdy=1 overwrites data_out; rdy stays 1.
- Latency: rdy and data_out update on the clk_50m edge following the clken tick that samples byte3's stop bit (mid-bit).
- frame_err is high for exactly one clk_50m cycle per error.
- clken=0 for any duration freezes the state machine. No spurious transitions.

Test Plan:
- Reset, then send word 0xDEADBEEF (clken every 27 clocks) -> data_out=0xDEADBEEF, rdy=1 after byte3 stop mid-bit, frame_err never high, Rx_busy=0 after guard.
- Two back-to-back words 0x00000000 then 0xFFFFFFFF, rdy_clr pulsed between them -> rdy rises twice; data_out = each word in turn. Guard bit produces no extra data or error.
- Byte1 stop bit forced to 0 in word 0x12345678 -> single-cycle frame_err, rdy stays 0. Next clean word 0xCAFEF00D received correctly.
- 2-tick low glitch on idle line -> false start: no rdy, no frame_err, back to IDLE.
- Line held high for 5 bit periods after byte1 -> frame_err pulse at 4 bit periods. Following full word 0xA5A5A5A5 received correctly.
- Assert rst during byte2 of 0x11223344 -> all outputs reset values next cycle. Subsequent word 0x55AA55AA received; rdy_clr coinciding with publish leaves rdy=1.

Source files
------------

// File: rtl/word_receiver.sv
// word_receiver: UART receive side of the 32-bit word link.
// Deserializes the four byte sub-frames (start, 8 data LSB-first, stop, stop)
// followed by the guard(0)/final-stop(1) pair, and publishes the word.
//
// Ports:
//   clk_50m   system clock
//   rst       synchronous active-high reset
//   Rx        serial line, idle high, asynchronous to clk_50m
//   clken     one-cycle strobe at OVERSAMPLE x baud
//   rdy_clr   consumer acknowledge, clears rdy
//   data_out  last complete word, byte0 in [7:0] ... byte3 in [31:24]
//   rdy       sticky new-word flag
//   frame_err one-cycle pulse on a framing or inter-byte timeout error
//   Rx_busy   high whenever the receiver is not idle
module word_receiver #(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        Rx,
  input  logic        clken,
  input  logic        rdy_clr,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        frame_err,
  output logic        Rx_busy
);

  localparam int HALF     = OVERSAMPLE / 2;
  localparam int TICK_W   = $clog2(OVERSAMPLE * 2);
  localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_HALF_LAST  = TICK_W'(HALF - 1);
  localparam logic [TICK_W-1:0] TICK_BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_GUARD_LAST = TICK_W'(OVERSAMPLE + HALF - 1);
  localparam logic [TO_W-1:0]   TO_LAST         = TO_W'(TO_TICKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, GUARD} state_t;

  state_t             state, state_nxt;
  logic [TICK_W-1:0]  tick, tick_nxt;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
  logic [1:0]         byte_idx, byte_idx_nxt;
  logic               armed, armed_nxt;
  logic               from_gap, from_gap_nxt;
  logic               guard_low, guard_low_nxt;
  logic [7:0]         shreg, shreg_nxt;
  logic [23:0]        word, word_nxt;
  logic               publish, err;

  // Stage p0/p1: two-flop synchronizer for the asynchronous line
  logic rx_p0, rx_p1;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= Rx;
      rx_p1 <= rx_p0;
    end
  end

  always_comb begin
    state_nxt     = state;
    tick_nxt      = tick;
    bit_cnt_nxt   = bit_cnt;
    to_cnt_nxt    = to_cnt;
    byte_idx_nxt  = byte_idx;
    armed_nxt     = armed;
    from_gap_nxt  = from_gap;
    guard_low_nxt = guard_low;
    shreg_nxt     = shreg;
    word_nxt      = word;
    publish       = 1'b0;
    err           = 1'b0;
    if (clken) begin
      case (state)
        IDLE: begin
          // A high tick must be seen before a low can start a frame, so a
          // line stuck low after an error cannot retrigger.
          if (!armed) begin
            if (rx_p1) armed_nxt = 1'b1;
          end else if (!rx_p1) begin
            state_nxt    = START;
            tick_nxt     = '0;
            from_gap_nxt = 1'b0;
          end
        end
        START: begin
          if (tick == TICK_HALF_LAST) begin
            if (!rx_p1) begin
              state_nxt   = DATA;
              tick_nxt    = '0;
              bit_cnt_nxt = '0;
            end else if (from_gap) begin
              state_nxt = GAP;
            end else begin
              state_nxt = IDLE;
              armed_nxt = 1'b1;
            end
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == TICK_BIT_LAST) begin
            shreg_nxt = {rx_p1, shreg[7:1]};
            tick_nxt  = '0;
            if (bit_cnt == 3'd7) state_nxt = STOP;
            else                 bit_cnt_nxt = bit_cnt + 1'b1;
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        STOP: begin
          if (tick == TICK_BIT_LAST) begin
            tick_nxt = '0;
            if (rx_p1) begin
              to_cnt_nxt = '0;
              if (byte_idx != 2'd3) begin
                case (byte_idx)
                  2'd0:    word_nxt[7:0]   = shreg;
                  2'd1:    word_nxt[15:8]  = shreg;
                  default: word_nxt[23:16] = shreg;
                endcase
                byte_idx_nxt = byte_idx + 1'b1;
                state_nxt    = GAP;
              end else begin
                publish       = 1'b1;
                byte_idx_nxt  = '0;
                guard_low_nxt = 1'b0;
                state_nxt     = GUARD;
              end
            end else begin
              err          = 1'b1;
              byte_idx_nxt = '0;
              armed_nxt    = 1'b0;
              state_nxt    = IDLE;
            end
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        GAP: begin
          // to_cnt survives a false start so glitches cannot extend the gap.
          if (!rx_p1) begin
            state_nxt    = START;
            tick_nxt     = '0;
            from_gap_nxt = 1'b1;
          end else if (to_cnt == TO_LAST) begin
            err          = 1'b1;
            byte_idx_nxt = '0;
            armed_nxt    = 1'b0;
            state_nxt    = IDLE;
          end else begin
            to_cnt_nxt = to_cnt + 1'b1;
          end
        end
        GUARD: begin
          // Swallow the guard low and ride out to the middle of the final stop.
          if (!guard_low) begin
            if (!rx_p1) begin
              guard_low_nxt = 1'b1;
              tick_nxt      = '0;
            end else if (to_cnt == TO_LAST) begin
              armed_nxt = 1'b0;
              state_nxt = IDLE;
            end else begin
              to_cnt_nxt = to_cnt + 1'b1;
            end
          end else if (tick == TICK_GUARD_LAST) begin
            armed_nxt = 1'b0;
            state_nxt = IDLE;
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          armed_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      byte_idx  <= '0;
      armed     <= 1'b0;
      from_gap  <= 1'b0;
      guard_low <= 1'b0;
      data_out  <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick      <= tick_nxt;
      bit_cnt   <= bit_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      byte_idx  <= byte_idx_nxt;
      armed     <= armed_nxt;
      from_gap  <= from_gap_nxt;
      guard_low <= guard_low_nxt;
      frame_err <= err;
      if (publish) data_out <= {shreg, word};
      // Publish wins over a simultaneous acknowledge.
      if (publish)      rdy <= 1'b1;
      else if (rdy_clr) rdy <= 1'b0;
    end
  end

  // Partial bytes need no reset: byte_idx restarts at 0 and every byte
  // is rewritten before the next publish.
  always_ff @(posedge clk_50m) begin
    shreg <= shreg_nxt;
    word  <= word_nxt;
  end

  assign Rx_busy = (state != IDLE);

endmodule
